// File: rtl/lc3b_types_pkg.sv
// Shared LC-3b types: opcodes, ALU operations, mux-select encodings,
// control-word layout and the control FSM state enum.
// Optional feature macro: LC3B_CTRL_INDIRECT_EN adds the LDI/STI states
// and the MDR input on the ALU operand mux.
package lc3b_types;

  // Instruction opcode, IR[15:12]
  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef enum logic [3:0] {
    alu_add  = 4'd0,
    alu_and  = 4'd1,
    alu_not  = 4'd2,
    alu_pass = 4'd3,
    alu_sll  = 4'd4,
    alu_srl  = 4'd5,
    alu_sra  = 4'd6
  } lc3b_aluop;

  typedef logic [1:0] lc3b_sel4mux;
  typedef logic [1:0] lc3b_mem_wmask;

  // PC input mux
  localparam lc3b_sel4mux pcmux_plus2 = 2'b00;  // PC + 2
  localparam lc3b_sel4mux pcmux_br    = 2'b01;  // PC + (offset9 << 1)
  localparam lc3b_sel4mux pcmux_baser = 2'b10;  // BaseR (JMP)

  // Register-file write-data mux
  localparam lc3b_sel4mux regfilemux_alu   = 2'b00;
  localparam lc3b_sel4mux regfilemux_mdr   = 2'b01;
  localparam lc3b_sel4mux regfilemux_pcoff = 2'b10;  // PC + (offset9 << 1), LEA

  // ALU B-operand mux
  localparam lc3b_sel4mux alumux_sr2  = 2'b00;
  localparam lc3b_sel4mux alumux_imm5 = 2'b01;
  localparam lc3b_sel4mux alumux_off6 = 2'b10;  // offset6 << 1
`ifdef LC3B_CTRL_INDIRECT_EN
  localparam lc3b_sel4mux alumux_mdr  = 2'b11;  // pointer value for MAR <- MDR
`endif

  // 2:1 mux selects
  localparam logic marmux_pc    = 1'b0;
  localparam logic marmux_alu   = 1'b1;
  localparam logic mdrmux_alu   = 1'b0;
  localparam logic mdrmux_mem   = 1'b1;
  localparam logic storemux_sr1 = 1'b0;
  localparam logic storemux_dr  = 1'b1;

  // Complete control word driven by the FSM
  typedef struct packed {
    logic          load_pc;
    logic          load_ir;
    logic          load_regfile;
    logic          load_mar;
    logic          load_mdr;
    logic          load_cc;
    lc3b_sel4mux   pcmux_sel;
    lc3b_sel4mux   regfilemux_sel;
    lc3b_sel4mux   alumux_sel;
    logic          marmux_sel;
    logic          mdrmux_sel;
    logic          storemux_sel;
    lc3b_aluop     aluop;
    logic          mem_read;
    logic          mem_write;
    lc3b_mem_wmask mem_byte_enable;
  } ctrl_t;

`ifdef LC3B_CTRL_INDIRECT_EN
  typedef enum logic [4:0] {
    FETCH1, FETCH2, FETCH3, DECODE,
    S_ADD, S_AND, S_NOT, S_BR, S_BR_TAKEN,
    S_CALC_ADDR, S_LDR1, S_LDR2, S_STR1, S_STR2,
    S_JMP, S_LEA,
    S_LDI1, S_LDI2, S_LDI3, S_LDI4,
    S_STI1, S_STI2, S_STI3, S_STI4
  } state_t;
`else
  typedef enum logic [3:0] {
    FETCH1, FETCH2, FETCH3, DECODE,
    S_ADD, S_AND, S_NOT, S_BR, S_BR_TAKEN,
    S_CALC_ADDR, S_LDR1, S_LDR2, S_STR1, S_STR2,
    S_JMP, S_LEA
  } state_t;
`endif

endpackage

// File: rtl/lc3b_control.sv
// LC-3b multicycle control unit: Moore FSM sequencing fetch, decode and
// execute of ADD/AND/NOT/BR/LDR/STR/JMP/LEA. Outputs decode from the
// current state only, forced to zero while reset_n is low.
// Optional feature macro: LC3B_CTRL_INDIRECT_EN adds LDI/STI sequencing;
// without it those opcodes decode as NOP.
module lc3b_control
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  lc3b_opcode    opcode,
  input  logic          ir_imm,
  input  logic          branch_enable,
  input  logic          mem_resp,
  output logic          load_pc,
  output logic          load_ir,
  output logic          load_regfile,
  output logic          load_mar,
  output logic          load_mdr,
  output logic          load_cc,
  output lc3b_sel4mux   pcmux_sel,
  output lc3b_sel4mux   regfilemux_sel,
  output lc3b_sel4mux   alumux_sel,
  output logic          marmux_sel,
  output logic          mdrmux_sel,
  output logic          storemux_sel,
  output lc3b_aluop     aluop,
  output logic          mem_read,
  output logic          mem_write,
  output lc3b_mem_wmask mem_byte_enable
);

  state_t state;
  state_t next_state;
  ctrl_t  ctrl;

  // State register with synchronous reset to FETCH1
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    if (!reset_n) state <= FETCH1;
    else          state <= next_state;
  end

  // Next-state logic; memory-wait states hold until mem_resp
  always_comb begin
    // NOTE: default assignment first so no path leaves next_state unassigned (no latch).
    next_state = state;
    case (state)
      FETCH1: next_state = FETCH2;
      FETCH2: if (mem_resp) next_state = FETCH3;
      FETCH3: next_state = DECODE;
      DECODE: begin
        case (opcode)
          op_add:         next_state = S_ADD;
          op_and:         next_state = S_AND;
          op_not:         next_state = S_NOT;
          op_br:          next_state = S_BR;
          op_ldr, op_str: next_state = S_CALC_ADDR;
`ifdef LC3B_CTRL_INDIRECT_EN
          op_ldi, op_sti: next_state = S_CALC_ADDR;
`endif
          op_jmp:         next_state = S_JMP;
          op_lea:         next_state = S_LEA;
          default:        next_state = FETCH1;
        endcase
      end
      S_BR: next_state = branch_enable ? S_BR_TAKEN : FETCH1;
      S_CALC_ADDR: begin
        case (opcode)
          op_ldr:  next_state = S_LDR1;
          op_str:  next_state = S_STR1;
`ifdef LC3B_CTRL_INDIRECT_EN
          op_ldi:  next_state = S_LDI1;
          op_sti:  next_state = S_STI1;
`endif
          default: next_state = FETCH1;
        endcase
      end
      S_LDR1: if (mem_resp) next_state = S_LDR2;
      S_STR1: next_state = S_STR2;
      S_STR2: if (mem_resp) next_state = FETCH1;
`ifdef LC3B_CTRL_INDIRECT_EN
      S_LDI1: if (mem_resp) next_state = S_LDI2;
      S_LDI2: next_state = S_LDI3;
      S_LDI3: if (mem_resp) next_state = S_LDI4;
      S_STI1: if (mem_resp) next_state = S_STI2;
      S_STI2: next_state = S_STI3;
      S_STI3: next_state = S_STI4;
      S_STI4: if (mem_resp) next_state = FETCH1;
`endif
      default: next_state = FETCH1;
    endcase
  end

  // Output decode from current state; everything idles to zero in reset
  always_comb begin
    ctrl = '0;
    ctrl.mem_byte_enable = 2'b11;
    case (state)
      FETCH1: begin
        ctrl.load_mar   = 1'b1;
        ctrl.marmux_sel = marmux_pc;
        ctrl.load_pc    = 1'b1;
        ctrl.pcmux_sel  = pcmux_plus2;
      end
      FETCH2: begin
        ctrl.mem_read   = 1'b1;
        ctrl.load_mdr   = 1'b1;
        ctrl.mdrmux_sel = mdrmux_mem;
      end
      FETCH3: ctrl.load_ir = 1'b1;
      S_ADD, S_AND: begin
        ctrl.aluop          = (state == S_ADD) ? alu_add : alu_and;
        ctrl.alumux_sel     = ir_imm ? alumux_imm5 : alumux_sr2;
        ctrl.regfilemux_sel = regfilemux_alu;
        ctrl.load_regfile   = 1'b1;
        ctrl.load_cc        = 1'b1;
      end
      S_NOT: begin
        ctrl.aluop        = alu_not;
        ctrl.load_regfile = 1'b1;
        ctrl.load_cc      = 1'b1;
      end
      S_BR_TAKEN: begin
        ctrl.pcmux_sel = pcmux_br;
        ctrl.load_pc   = 1'b1;
      end
      S_CALC_ADDR: begin
        ctrl.alumux_sel = alumux_off6;
        ctrl.aluop      = alu_add;
        ctrl.load_mar   = 1'b1;
        ctrl.marmux_sel = marmux_alu;
      end
      S_LDR1: begin
        ctrl.mem_read   = 1'b1;
        ctrl.load_mdr   = 1'b1;
        ctrl.mdrmux_sel = mdrmux_mem;
      end
      S_LDR2: begin
        ctrl.regfilemux_sel = regfilemux_mdr;
        ctrl.load_regfile   = 1'b1;
        ctrl.load_cc        = 1'b1;
      end
      S_STR1: begin
        ctrl.storemux_sel = storemux_dr;
        ctrl.aluop        = alu_pass;
        ctrl.load_mdr     = 1'b1;
        ctrl.mdrmux_sel   = mdrmux_alu;
      end
      S_STR2: ctrl.mem_write = 1'b1;
      S_JMP: begin
        ctrl.pcmux_sel = pcmux_baser;
        ctrl.load_pc   = 1'b1;
      end
      S_LEA: begin
        ctrl.regfilemux_sel = regfilemux_pcoff;
        ctrl.load_regfile   = 1'b1;
        ctrl.load_cc        = 1'b1;
      end
`ifdef LC3B_CTRL_INDIRECT_EN
      S_LDI1, S_LDI3, S_STI1: begin
        ctrl.mem_read   = 1'b1;
        ctrl.load_mdr   = 1'b1;
        ctrl.mdrmux_sel = mdrmux_mem;
      end
      S_LDI2, S_STI2: begin
        ctrl.alumux_sel = alumux_mdr;
        ctrl.aluop      = alu_pass;
        ctrl.load_mar   = 1'b1;
        ctrl.marmux_sel = marmux_alu;
      end
      S_LDI4: begin
        ctrl.regfilemux_sel = regfilemux_mdr;
        ctrl.load_regfile   = 1'b1;
        ctrl.load_cc        = 1'b1;
      end
      S_STI3: begin
        ctrl.storemux_sel = storemux_dr;
        ctrl.aluop        = alu_pass;
        ctrl.load_mdr     = 1'b1;
        ctrl.mdrmux_sel   = mdrmux_alu;
      end
      S_STI4: ctrl.mem_write = 1'b1;
`endif
      default: ;
    endcase
    // Reset must silence strobes immediately, even mid-access
    if (!reset_n) ctrl = '0;
  end

  assign load_pc         = ctrl.load_pc;
  assign load_ir         = ctrl.load_ir;
  assign load_regfile    = ctrl.load_regfile;
  assign load_mar        = ctrl.load_mar;
  assign load_mdr        = ctrl.load_mdr;
  assign load_cc         = ctrl.load_cc;
  assign pcmux_sel       = ctrl.pcmux_sel;
  assign regfilemux_sel  = ctrl.regfilemux_sel;
  assign alumux_sel      = ctrl.alumux_sel;
  assign marmux_sel      = ctrl.marmux_sel;
  assign mdrmux_sel      = ctrl.mdrmux_sel;
  assign storemux_sel    = ctrl.storemux_sel;
  assign aluop           = ctrl.aluop;
  assign mem_read        = ctrl.mem_read;
  assign mem_write       = ctrl.mem_write;
  assign mem_byte_enable = ctrl.mem_byte_enable;

endmodule

// File: tb/tb_lc3b_control.sv
// Testbench for lc3b_control: per-cycle scoreboard of the full control word.
// Expected words are queued per instruction, then popped and compared at
// each falling edge. Honors LC3B_CTRL_INDIRECT_EN for the LDI step.
module tb_lc3b_control;
  import lc3b_types::*;

  logic          clk;
  logic          reset_n;
  lc3b_opcode    opcode;
  logic          ir_imm;
  logic          branch_enable;
  logic          mem_resp;
  logic          load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc;
  lc3b_sel4mux   pcmux_sel, regfilemux_sel, alumux_sel;
  logic          marmux_sel, mdrmux_sel, storemux_sel;
  lc3b_aluop     aluop;
  logic          mem_read, mem_write;
  lc3b_mem_wmask mem_byte_enable;

  lc3b_control dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .opcode         (opcode),
    .ir_imm         (ir_imm),
    .branch_enable  (branch_enable),
    .mem_resp       (mem_resp),
    .load_pc        (load_pc),
    .load_ir        (load_ir),
    .load_regfile   (load_regfile),
    .load_mar       (load_mar),
    .load_mdr       (load_mdr),
    .load_cc        (load_cc),
    .pcmux_sel      (pcmux_sel),
    .regfilemux_sel (regfilemux_sel),
    .alumux_sel     (alumux_sel),
    .marmux_sel     (marmux_sel),
    .mdrmux_sel     (mdrmux_sel),
    .storemux_sel   (storemux_sel),
    .aluop          (aluop),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_byte_enable(mem_byte_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       load_pc;
    logic       load_ir;
    logic       load_regfile;
    logic       load_mar;
    logic       load_mdr;
    logic       load_cc;
    logic [1:0] pcmux;
    logic [1:0] regmux;
    logic [1:0] alumux;
    logic       marmux;
    logic       mdrmux;
    logic       storemux;
    logic [3:0] aluop;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] be;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  e;
  } sb_t;

  sb_t sb_q[$];
  int  checks = 0;
  int  errors = 0;

  // Expected control word for a state, written from the state descriptions
  function automatic obs_t exp_for(input state_t s, input logic imm);
    obs_t o;
    o = '0;
    o.be = 2'b11;
    case (s)
      FETCH1: begin
        o.load_mar = 1'b1; o.marmux = marmux_pc;
        o.load_pc = 1'b1;  o.pcmux = pcmux_plus2;
      end
      FETCH2, S_LDR1: begin
        o.mem_read = 1'b1; o.load_mdr = 1'b1; o.mdrmux = mdrmux_mem;
      end
      FETCH3: o.load_ir = 1'b1;
      S_ADD, S_AND: begin
        o.aluop = (s == S_ADD) ? 4'd0 : 4'd1;
        o.alumux = imm ? alumux_imm5 : alumux_sr2;
        o.regmux = regfilemux_alu; o.load_regfile = 1'b1; o.load_cc = 1'b1;
      end
      S_NOT: begin
        o.aluop = 4'd2; o.load_regfile = 1'b1; o.load_cc = 1'b1;
      end
      S_BR_TAKEN: begin
        o.pcmux = pcmux_br; o.load_pc = 1'b1;
      end
      S_CALC_ADDR: begin
        o.alumux = alumux_off6; o.aluop = 4'd0;
        o.load_mar = 1'b1; o.marmux = marmux_alu;
      end
      S_LDR2: begin
        o.regmux = regfilemux_mdr; o.load_regfile = 1'b1; o.load_cc = 1'b1;
      end
      S_STR1: begin
        o.storemux = storemux_dr; o.aluop = 4'd3;
        o.load_mdr = 1'b1; o.mdrmux = mdrmux_alu;
      end
      S_STR2: o.mem_write = 1'b1;
      S_JMP: begin
        o.pcmux = pcmux_baser; o.load_pc = 1'b1;
      end
      S_LEA: begin
        o.regmux = regfilemux_pcoff; o.load_regfile = 1'b1; o.load_cc = 1'b1;
      end
`ifdef LC3B_CTRL_INDIRECT_EN
      S_LDI1, S_LDI3: begin
        o.mem_read = 1'b1; o.load_mdr = 1'b1; o.mdrmux = mdrmux_mem;
      end
      S_LDI2: begin
        o.alumux = alumux_mdr; o.aluop = 4'd3;
        o.load_mar = 1'b1; o.marmux = marmux_alu;
      end
      S_LDI4: begin
        o.regmux = regfilemux_mdr; o.load_regfile = 1'b1; o.load_cc = 1'b1;
      end
`endif
      default: ;
    endcase
    return o;
  endfunction

  task automatic push(input string tag, input obs_t e);
    sb_t item;
    item.tag = tag;
    item.e   = e;
    sb_q.push_back(item);
  endtask

  task automatic push_state(input string tag, input state_t s);
    push(tag, exp_for(s, ir_imm));
  endtask

  // FETCH1, FETCH2 for (waits+1) cycles, FETCH3, DECODE
  task automatic push_fetch(input int waits);
    push_state("fetch1", FETCH1);
    for (int i = 0; i <= waits; i++) push_state("fetch2", FETCH2);
    push_state("fetch3", FETCH3);
    push_state("decode", DECODE);
  endtask

  task automatic check();
    obs_t obs;
    sb_t  item;
    obs = {load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc,
           pcmux_sel, regfilemux_sel, alumux_sel, marmux_sel, mdrmux_sel,
           storemux_sel, aluop, mem_read, mem_write, mem_byte_enable};
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_underflow observed=%h expected=<none>", obs);
    end else begin
      item = sb_q.pop_front();
      assert (obs === item.e) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", item.tag, obs, item.e);
      end
    end
  endtask

  // Run n cycles; bit i of resp/rst drives mem_resp / holds reset in cycle i
  task automatic run(input int n, input logic [31:0] resp, input logic [31:0] rst);
    for (int i = 0; i < n; i++) begin
      reset_n  = ~rst[i];
      mem_resp = resp[i];
      @(negedge clk);
      check();
      @(posedge clk);
      #1;
    end
    mem_resp = 1'b0;
    reset_n  = 1'b1;
  endtask

  initial begin
    reset_n       = 1'b0;
    mem_resp      = 1'b0;
    opcode        = op_br;
    ir_imm        = 1'b0;
    branch_enable = 1'b0;

    // Reset: every output zero, byte enable included
    push("reset0", '0);
    push("reset1", '0);
    run(2, 32'h0, 32'h3);

    // ADD immediate, memory answers after 3 wait cycles
    opcode = op_add; ir_imm = 1'b1;
    push_fetch(3);
    push_state("add_imm", S_ADD);
    run(8, 32'h1 << 4, 32'h0);

    // AND register form, stray mem_resp in FETCH1
    opcode = op_and; ir_imm = 1'b0;
    push_fetch(1);
    push_state("and_reg", S_AND);
    run(6, 32'b101, 32'h0);

    // NOT
    opcode = op_not;
    push_fetch(0);
    push_state("not", S_NOT);
    run(5, 32'h2, 32'h0);

    // BR not taken: no load_pc after S_BR
    opcode = op_br; branch_enable = 1'b0;
    push_fetch(0);
    push_state("br_nt", S_BR);
    run(5, 32'h2, 32'h0);

    // BR taken: S_BR_TAKEN loads PC once
    branch_enable = 1'b1;
    push_fetch(0);
    push_state("br_t", S_BR);
    push_state("br_taken", S_BR_TAKEN);
    run(6, 32'h2, 32'h0);
    branch_enable = 1'b0;

    // STR with 5-cycle memory delay: mem_write held 6 cycles
    opcode = op_str;
    push_fetch(0);
    push_state("str_calc", S_CALC_ADDR);
    push_state("str1", S_STR1);
    for (int i = 0; i < 6; i++) push_state("str2_wait", S_STR2);
    run(12, 32'h2 | (32'h1 << 11), 32'h0);

    // LDR with one wait cycle
    opcode = op_ldr;
    push_fetch(0);
    push_state("ldr_calc", S_CALC_ADDR);
    push_state("ldr1", S_LDR1);
    push_state("ldr1", S_LDR1);
    push_state("ldr2", S_LDR2);
    run(8, 32'h2 | (32'h1 << 6), 32'h0);

    // JMP and LEA
    opcode = op_jmp;
    push_fetch(0);
    push_state("jmp", S_JMP);
    run(5, 32'h2, 32'h0);
    opcode = op_lea;
    push_fetch(0);
    push_state("lea", S_LEA);
    run(5, 32'h2, 32'h0);

    // RTI decodes as NOP
    opcode = op_rti;
    push_fetch(0);
    run(4, 32'h2, 32'h0);

    // LDI: NOP without the indirect feature, two reads with it
    opcode = op_ldi;
    push_fetch(0);
`ifdef LC3B_CTRL_INDIRECT_EN
    push_state("ldi_calc", S_CALC_ADDR);
    push_state("ldi1", S_LDI1);
    push_state("ldi2", S_LDI2);
    push_state("ldi3", S_LDI3);
    push_state("ldi4", S_LDI4);
    run(9, 32'h2 | (32'h1 << 5) | (32'h1 << 7), 32'h0);
`else
    run(4, 32'h2, 32'h0);
`endif

    // Reset during the LDR1 wait, then a stray mem_resp in FETCH1
    opcode = op_ldr;
    push_fetch(0);
    push_state("rst_calc", S_CALC_ADDR);
    push_state("rst_ldr1", S_LDR1);
    push("rst_mid_ldr1", '0);
    push_state("rst_fetch1", FETCH1);
    push_state("rst_fetch2_hold", FETCH2);
    push_state("rst_fetch2_resp", FETCH2);
    run(10, 32'h2 | (32'h1 << 7) | (32'h1 << 9), 32'h1 << 6);
    opcode = op_rti;
    push_state("rst_fetch3", FETCH3);
    push_state("rst_decode", DECODE);
    push_state("final_fetch1", FETCH1);
    run(3, 32'h0, 32'h0);

    // Every queued expectation must have been consumed
    checks++;
    assert (sb_q.size() === 0) else begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc3b_control.md
LC3B_CONTROL -- requirements
Module: lc3b_control

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset_n  input  1  synchronous active-low reset.
REQ-004 opcode  input  4  decoded IR[15:12], type lc3b_opcode.
REQ-005 ir_imm  input  1  IR[5]; 1 = ADD/AND immediate form.
REQ-006 branch_enable  input  1  NZP match from CC logic.
REQ-007 mem_resp  input  1  memory access complete, single-cycle pulse.
REQ-008 load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc  output  1 each  datapath register enables.
REQ-009 pcmux_sel, regfilemux_sel, alumux_sel  output  2 each  lc3b_sel4mux selects.
REQ-010 marmux_sel, mdrmux_sel, storemux_sel  output  1 each  2:1 mux selects.
REQ-011 aluop  output  4  lc3b_aluop.
REQ-012 mem_read, mem_write  output  1 each  memory request strobes.
REQ-013 mem_byte_enable  output  2  lc3b_mem_wmask; 2'b11 for all word accesses.

Function
REQ-014 Moore FSM; all outputs decoded from current state only, default-zero per state except mem_byte_enable = 2'b11.
REQ-015 States: FETCH1, FETCH2, FETCH3, DECODE, S_ADD, S_AND, S_NOT, S_BR, S_BR_TAKEN, S_CALC_ADDR, S_LDR1, S_LDR2, S_STR1, S_STR2, S_JMP, S_LEA.
REQ-016 FETCH1: load_mar (marmux=PC), load_pc (pcmux=PC+2); -> FETCH2.
REQ-017 FETCH2: mem_read, load_mdr (mdrmux=mem); stay until mem_resp, then -> FETCH3.
REQ-018 FETCH3: load_ir; -> DECODE.
REQ-019 DECODE: no enables; next state by opcode: add->S_ADD, and->S_AND, not->S_NOT, br->S_BR, ldr/str->S_CALC_ADDR, jmp->S_JMP, lea->S_LEA; any other opcode -> FETCH1 (NOP).
REQ-020 S_ADD/S_AND: aluop add/and, alumux=imm5 when ir_imm else SR2, regfilemux=ALU, load_regfile, load_cc; -> FETCH1.
REQ-021 S_NOT: aluop not, load_regfile, load_cc; -> FETCH1.
REQ-022 S_BR: -> S_BR_TAKEN if branch_enable else FETCH1; S_BR_TAKEN: pcmux=PC+offset9<<1, load_pc; -> FETCH1.
REQ-023 S_CALC_ADDR: alumux=offset6<<1, aluop add, load_mar (marmux=ALU); -> S_LDR1 for ldr, S_STR1 for str.
REQ-024 S_LDR1: mem_read, load_mdr; hold until mem_resp -> S_LDR2; S_LDR2: regfilemux=MDR, load_regfile, load_cc; -> FETCH1.
REQ-025 S_STR1: storemux=DR field, aluop pass, load_mdr (mdrmux=ALU); -> S_STR2; S_STR2: mem_write; hold until mem_resp -> FETCH1.
REQ-026 S_JMP: pcmux=BaseR, load_pc; S_LEA: regfilemux=PC+offset9<<1, load_regfile, load_cc; both -> FETCH1.
REQ-027 mem_read/mem_write SHALL stay asserted continuously until the mem_resp cycle and deassert the following cycle; never both asserted.
REQ-028 mem_resp outside a memory-wait state SHALL be ignored.

Reset
REQ-029 reset_n low at a rising edge SHALL set state to FETCH1, regardless of current state or pending memory access.
REQ-030 While reset_n low, all outputs SHALL be 0 (mem_byte_enable 2'b00), including mid-access mem_read/mem_write.

Configuration
REQ-031 Macro LC3B_CTRL_INDIRECT_EN: when defined, adds states S_LDI1..S_LDI4 and S_STI1..S_STI4 (MAR<-addr, read pointer, MAR<-MDR, then read/write data), ldi/sti decoded to S_CALC_ADDR.
REQ-032 Without LC3B_CTRL_INDIRECT_EN, ldi/sti SHALL decode as NOP (DECODE -> FETCH1), no extra states synthesized.

Structure
REQ-033 State enum, all mux-select constant encodings, and opcode/aluop types SHALL live in shared package lc3b_types.
REQ-034 Single module; next-state and output decode in separate combinational blocks; no sub-module.

Verification
REQ-035 Reset then release; ADD imm opcode 4'b0001, ir_imm=1, mem_resp after 3 waits -> FETCH2 holds mem_read 4 cycles; S_ADD asserts load_regfile, load_cc, alumux=imm; back to FETCH1 in 8 cycles total.
REQ-036 BR 4'b0000 with branch_enable=0 -> FETCH1 after S_BR, no load_pc; with branch_enable=1 -> S_BR_TAKEN asserts load_pc once.
REQ-037 STR 4'b0111, mem_resp delayed 5 cycles -> mem_write held 6 cycles, mem_read never asserted, return to FETCH1.
REQ-038 reset_n low during S_LDR1 wait -> outputs 0 that cycle, FETCH1 next; stray mem_resp afterward ignored.
REQ-039 Opcode 4'b1000 (rti) and, without macro, 4'b1010 (ldi) -> DECODE then FETCH1, no enables; with macro, ldi completes two mem_read transactions.
